imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Inverse of the immediate decode path. Takes a signed 32-bit immediate, an immediate format and a base instruction word, and packs the immediate into the RISC-V I/S/B/J bit positions. Checks range and alignment, and flags any value that the decode path could not reproduce. Sits in the test-program loader / instruction-memory initialiser. Two-stage valid/ready pipeline with full throughput.

Parameters:
CNT_W, 16, width of the encoded-instruction and error counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
fmt  input  2  00=I, 01=S, 10=B, 11=J (same select encoding as the immediate decoder)
imm  input  32  signed immediate value in bytes
base  input  32  instruction word; immediate bit positions of fmt are ignored
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
instr  output  32  encoded instruction
err  output  1  immediate not encodable
err_code  output  2  01=range, 10=misaligned, 11=both, 00=ok
enc_count  output  CNT_W  completed handshakes, wraps
err_count  output  CNT_W  completed handshakes with err=1, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): both stage-valid flags 0, out_valid=0, instr=0, err=0, err_code=00, counters 0. in_ready=1 after reset deasserts. Reset mid-operation drops in-flight requests with no output.
- Stage 1 (check) registers fmt, imm, base, err_code. Stage 2 (merge) drives the outputs.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Input transfer occurs on in_valid&&in_ready.
  - Output transfer occurs on out_valid&&out_ready.
  - s2 accepts when !s2_valid || out_ready.
  - s1 advances when s2 accepts.
  - in_ready = !s1_valid || s2 accepts. in_ready is combinational from out_ready; there is no in_valid→in_ready path.
  - Outputs hold stable while out_valid && !out_ready.
- Range checks (imm signed):
  - I, S: -2048..2047
  - B: -4096..4094
  - J: -1048576..1048574
- Alignment: B and J require imm[0]=0. I and S have no alignment check.
- Field mask M(fmt):
  - I: [31:20]
  - S: [31:25],[11:7]
  - B: [31:25],[11:7]
  - J: [31:12]
- Merge: instr = (base & ~M) | field.
  - I: instr[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- On err: field = 0 (masked bits forced 0), non-immediate bits of base pass unchanged, err=1.
- Round-trip property: for every legal imm, decoding instr with the same format select returns exactly imm.
- Counters update on the output handshake only. enc_count increments by 1 and wraps. err_count increments only if err=1 and saturates.
- Simultaneous input and output handshake in a full pipe: no bubble, no loss, no duplication.

Test Plan:
- fmt=I, imm=-1, base=0x00000013 → instr=0xFFF00013, err=0, out_valid 2 cycles after the input handshake.
- fmt=S, imm=0x7FF, base=0x00002023 → instr=0x7E002FA3. Then imm=2048 → err=1, err_code=01, instr=0x00002023.
- fmt=B, imm=-4096, base=0x00000063 → instr=0x80000063. Then imm=3 → err_code=10. Then imm=4097 → err_code=11.
- fmt=J, imm=0x000FFFFE, base=0x0000006F → instr=0x7FFFF06F. Then imm=0x100000 → err_code=01.
- Backpressure: stream 8 requests, hold out_ready=0 for 5 cycles. Required: in_ready=0 once both stages are full, outputs stable, all 8 delivered in order, enc_count=8.
- Assert rst_n low with both stages full → out_valid=0 immediately and counters 0. Then 2^CNT_W+3 erroneous requests → err_count=all-ones, enc_count=3.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a signed immediate into the RISC-V I/S/B/J bit positions of a base word.
// Two-stage valid/ready pipeline: stage 1 checks range/alignment, stage 2 merges.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       fmt,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int STAGES = 2;

  // imm bits above 20 never reach an instruction field, so stage 1 keeps only [20:0]
  typedef struct packed {
    logic [1:0]  fmt;
    logic [20:0] imm;
    logic [31:0] base;
    logic [1:0]  ecode;
  } s1_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  ecode;
  } s2_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d, s1_nxt;
  s2_t             s2_q, s2_d, s2_nxt;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic            s2_acc, in_fire, out_fire;
  logic            rng_bad, mis;
  logic [31:0]     mask, field;

  assign s2_acc   = !vld_pipe_q[2] || out_ready;
  assign in_ready = !vld_pipe_q[1] || s2_acc;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_pipe_q[2] && out_ready;

  always_comb begin
    rng_bad = 1'b0;
    case (fmt)
      2'b00, 2'b01: rng_bad = ($signed(imm) < -32'sd2048)    || ($signed(imm) > 32'sd2047);
      2'b10:        rng_bad = ($signed(imm) < -32'sd4096)    || ($signed(imm) > 32'sd4094);
      default:      rng_bad = ($signed(imm) < -32'sd1048576) || ($signed(imm) > 32'sd1048574);
    endcase
    mis = fmt[1] & imm[0];
    s1_nxt.fmt   = fmt;
    s1_nxt.imm   = imm[20:0];
    s1_nxt.base  = base;
    s1_nxt.ecode = {mis, rng_bad};
    s1_d = in_fire ? s1_nxt : s1_q;
  end

  always_comb begin
    mask  = 32'h0;
    field = 32'h0;
    case (s1_q.fmt)
      2'b00: begin
        mask  = 32'hFFF0_0000;
        field = {s1_q.imm[11:0], 20'b0};
      end
      2'b01: begin
        mask  = 32'hFE00_0F80;
        field = {s1_q.imm[11:5], 13'b0, s1_q.imm[4:0], 7'b0};
      end
      2'b10: begin
        mask  = 32'hFE00_0F80;
        field = {s1_q.imm[12], s1_q.imm[10:5], 13'b0, s1_q.imm[4:1], s1_q.imm[11], 7'b0};
      end
      default: begin
        mask  = 32'hFFFF_F000;
        field = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12], 12'b0};
      end
    endcase
    // an unencodable immediate leaves its field zeroed rather than truncated
    s2_nxt.instr = (s1_q.base & ~mask) | ((|s1_q.ecode) ? 32'h0 : field);
    s2_nxt.ecode = s1_q.ecode;
    s2_d = (s2_acc && vld_pipe_q[1]) ? s2_nxt : s2_q;
  end

  always_comb begin
    vld_pipe_d[1] = in_ready ? in_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_acc ? vld_pipe_q[1] : vld_pipe_q[2];
    enc_cnt_d = out_fire ? enc_cnt_q + CNT_W'(1) : enc_cnt_q;
    err_cnt_d = (out_fire && err && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign instr     = s2_q.instr;
  assign err       = |s2_q.ecode;
  assign err_code  = s2_q.ecode;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed test-plan cases, random traffic
// with backpressure, a stall/hold check, mid-flight reset and counter limits.
module tb_imm_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       fmt = '0;
  logic [31:0]      imm = '0;
  logic [31:0]      base = '0;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] enc_count, err_count;

  logic or_cmd = 1'b1;
  logic rnd_bp = 1'b0;

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [1:0]  code;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .imm(imm), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .err_code(err_code),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : or_cmd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dec(input logic [1:0] f, input logic [31:0] i);
    case (f)
      2'b00:   dec = {{20{i[31]}}, i[31:20]};
      2'b01:   dec = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   dec = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: dec = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b);
    exp_t e;
    int v, lo, hi;
    logic r, m;
    logic [31:0] w;
    v = i;
    case (f)
      2'b00, 2'b01: begin lo = -2048;    hi = 2047;    end
      2'b10:        begin lo = -4096;    hi = 4094;    end
      default:      begin lo = -1048576; hi = 1048574; end
    endcase
    r = (v < lo) || (v > hi);
    m = (f >= 2'b10) && i[0];
    w = b;
    case (f)
      2'b00: begin w[31:20] = '0; if (!(r || m)) w[31:20] = i[11:0]; end
      2'b01: begin
        w[31:25] = '0; w[11:7] = '0;
        if (!(r || m)) begin w[31:25] = i[11:5]; w[11:7] = i[4:0]; end
      end
      2'b10: begin
        w[31:25] = '0; w[11:7] = '0;
        if (!(r || m)) begin w[31] = i[12]; w[30:25] = i[10:5]; w[11:8] = i[4:1]; w[7] = i[11]; end
      end
      default: begin
        w[31:12] = '0;
        if (!(r || m)) begin w[31] = i[20]; w[30:21] = i[10:1]; w[20] = i[11]; w[19:12] = i[19:12]; end
      end
    endcase
    e.fmt = f; e.imm = i; e.instr = w; e.code = {m, r};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("err", 32'(err), 32'(|e.code));
        if (e.code == 2'b00) chk("round_trip", dec(e.fmt, instr), e.imm);
      end
    end
  end

  // Drive one request; push the expectation at the cycle it is accepted.
  task automatic send(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b,
                      input exp_t e);
    int t;
    fmt = f; imm = i; base = b; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      if (++t > 50) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b);
    send(f, i, b, model(f, i, b));
  endtask

  task automatic send_c(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b,
                        input logic [31:0] ei, input logic [1:0] ec);
    exp_t e;
    e.fmt = f; e.imm = i; e.instr = ei; e.code = ec;
    send(f, i, b, e);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk(tag, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int bnd[4][4] = '{'{-2048, 2047, -2049, 2048},
                    '{-2048, 2047, -2049, 2048},
                    '{-4096, 4094, -4097, 4095},
                    '{-1048576, 1048574, -1048577, 1048575}};

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: out_valid two cycles after the input handshake
    send_c(2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    drain("drain_lat");

    send_c(2'b01, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 2'b00);
    send_c(2'b01, 32'd2048,      32'h0000_2023, 32'h0000_2023, 2'b01);
    send_c(2'b10, -32'sd4096,    32'h0000_0063, 32'h8000_0063, 2'b00);
    send_c(2'b10, 32'd3,         32'h0000_0063, 32'h0000_0063, 2'b10);
    send_c(2'b10, 32'd4097,      32'h0000_0063, 32'h0000_0063, 2'b11);
    send_c(2'b11, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 2'b00);
    send_c(2'b11, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 2'b01);
    drain("drain_directed");
    chk("enc_count_directed", 32'(enc_count), 32'd8);
    chk("err_count_directed", 32'(err_count), 32'd4);

    // Random traffic under random backpressure
    rnd_bp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [1:0] f;
      logic [31:0] i;
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: i = 32'($urandom_range(0, 10000)) - 32'd5000;
        1: i = 32'(bnd[f][$urandom_range(0, 3)]);
        2: i = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: i = $urandom;
      endcase
      send_m(f, i, $urandom);
    end
    rnd_bp = 1'b0;
    or_cmd = 1'b1;
    drain("drain_random");

    // Backpressure: fill both stages, hold 5 cycles, then release
    do_reset();
    or_cmd = 1'b0;
    @(posedge clk); #1;
    send_m(2'b00, 32'd100, 32'hA5A5_A5A5);
    send_m(2'b01, -32'sd7, 32'h1234_5678);
    fmt = 2'b10; imm = 32'd40; base = 32'hCAFE_F00D; in_valid = 1'b1;
    begin
      logic [31:0] held;
      @(negedge clk);
      held = instr;
      for (int c = 0; c < 5; c++) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_instr_hold", instr, held);
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    or_cmd = 1'b1;
    send_m(2'b10, 32'd40, 32'hCAFE_F00D);
    for (int n = 0; n < 5; n++) send_m(2'(n), 32'(n * 64 - 130), 32'(n) * 32'h0101_0101);
    drain("drain_bp");
    chk("bp_enc_count", 32'(enc_count), 32'd8);

    // Reset with both stages full
    or_cmd = 1'b0;
    @(posedge clk); #1;
    send_m(2'b00, 32'd1, 32'h0);
    send_m(2'b00, 32'd2, 32'h0);
    @(posedge clk); #1;
    chk("full_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_enc_count", 32'(enc_count), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    sb.delete();
    or_cmd = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // 2^CNT_W+3 erroneous requests: err_count saturates, enc_count wraps to 3
    for (int n = 0; n < (1 << CNT_W) + 3; n++)
      send_m(2'b00, 32'd4096, 32'hFFFF_FFFF);
    drain("drain_sat");
    chk("sat_err_count", 32'(err_count), 32'((1 << CNT_W) - 1));
    chk("wrap_enc_count", 32'(enc_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
